// File: rtl/fa_bist.sv
// Exhaustive full-adder BIST: sweeps {ci,a,b} = 0..7, waits SETTLE_CYC cycles per
// vector, then compares dut_s/dut_co against a golden model. Optional FA_BIST_FAIL_CAPTURE_EN.
module fa_bist #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_s,
    input  logic       dut_co,
    output logic       ci,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt
`ifdef FA_BIST_FAIL_CAPTURE_EN
    ,
    output logic       fail_vld,
    output logic [2:0] fail_vec
`endif
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [2:0] vec;
    logic [3:0] cnt;
    logic       exp_s, exp_co, mism;
    logic [3:0] err_nxt;

    // Golden model works off the registered stimulus, not vec.
    assign exp_s   = ci ^ a ^ b;
    assign exp_co  = (a & b) | (ci & (a ^ b));
    assign mism    = (dut_s != exp_s) | (dut_co != exp_co);
    assign err_nxt = (mism && err_cnt != 4'd8) ? err_cnt + 4'd1 : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            {ci, a, b} <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 4'd0;
            vec      <= 3'd0;
            cnt      <= 4'd0;
`ifdef FA_BIST_FAIL_CAPTURE_EN
            fail_vld <= 1'b0;
            fail_vec <= 3'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= DRIVE;
                        busy     <= 1'b1;
                        err_cnt  <= 4'd0;
                        pass     <= 1'b0;
                        vec      <= 3'd0;
`ifdef FA_BIST_FAIL_CAPTURE_EN
                        fail_vld <= 1'b0;
                        fail_vec <= 3'd0;
`endif
                    end
                end
                DRIVE: begin
                    {ci, a, b} <= vec;
                    cnt        <= 4'd0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST) state <= CHECK;
                end
                CHECK: begin
                    err_cnt <= err_nxt;
`ifdef FA_BIST_FAIL_CAPTURE_EN
                    if (mism && !fail_vld) begin
                        fail_vld <= 1'b1;
                        fail_vec <= {ci, a, b};
                    end
`endif
                    // pass must include this last CHECK's result, hence err_nxt.
                    if (vec == 3'd7) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_nxt == 4'd0);
                    end else begin
                        vec   <= vec + 3'd1;
                        state <= DRIVE;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_bist.sv
// Scoreboard bench for fa_bist: three instances (SETTLE_CYC 1/2/15) driving a
// behavioural full adder with selectable faults.
module tb_fa_bist;

    typedef struct {
        int         inst;
        int         lat;
        int         err;
        logic       pass;
        logic       fvld;
        logic [2:0] fvec;
        int         st;
    } exp_t;

    localparam int SC[3]  = '{1, 2, 15};
    localparam int LAT[3] = '{25, 33, 137};

    logic clk, rst_n;
    logic start [3];
    logic ci_w [3], a_w [3], b_w [3], busy_w [3], done_w [3], pass_w [3];
    logic s_w [3], co_w [3];
    logic [3:0] err_w [3];
`ifdef FA_BIST_FAIL_CAPTURE_EN
    logic       fvld_w [3];
    logic [2:0] fvec_w [3];
`endif

    int   mode;          // 0 good, 1 co stuck-at-0, 2 s inverted
    int   cyc;
    int   checks, failures;
    int   donecnt [3];
    int   st [3];
    exp_t sb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fa_bist #(.SETTLE_CYC(g == 0 ? 1 : (g == 1 ? 2 : 15))) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start[g]),
            .dut_s   (s_w[g]),
            .dut_co  (co_w[g]),
            .ci      (ci_w[g]),
            .a       (a_w[g]),
            .b       (b_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g]),
            .pass    (pass_w[g]),
            .err_cnt (err_w[g])
`ifdef FA_BIST_FAIL_CAPTURE_EN
            ,
            .fail_vld(fvld_w[g]),
            .fail_vec(fvec_w[g])
`endif
        );
        assign s_w[g]  = ci_w[g] ^ a_w[g] ^ b_w[g] ^ (mode == 2);
        assign co_w[g] = (mode == 1) ? 1'b0 :
                         ((a_w[g] & b_w[g]) | (a_w[g] & ci_w[g]) | (b_w[g] & ci_w[g]));
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; also checks vector order.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_w[i]) begin
                donecnt[i]++;
                if (sb.size() == 0) begin
                    chk("spurious_done", done_w[i], 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_inst", i, e.inst);
                    chk("latency", cyc - e.st, e.lat);
                    chk("err_cnt", err_w[i], e.err);
                    chk("pass", pass_w[i], e.pass);
                    chk("busy_at_done", busy_w[i], 0);
`ifdef FA_BIST_FAIL_CAPTURE_EN
                    chk("fail_vld", fvld_w[i], e.fvld);
                    if (e.fvld) chk("fail_vec", fvec_w[i], e.fvec);
`endif
                end
            end
            if (busy_w[i] && st[i] >= 0) begin
                int off;
                off = cyc - st[i] - 2;
                if (off >= 0 && (off % (SC[i] + 2)) == SC[i])
                    chk("vec_order", {ci_w[i], a_w[i], b_w[i]}, off / (SC[i] + 2));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic issue(input int i, input int err, input logic ps, input logic fv,
                         input logic [2:0] fvec);
        exp_t e;
        e.inst = i; e.lat = LAT[i]; e.err = err; e.pass = ps;
        e.fvld = fv; e.fvec = fvec; e.st = cyc;
        st[i] = cyc;
        sb.push_back(e);
        start[i] = 1'b1;
        step(1);
        start[i] = 1'b0;
    endtask

    task automatic pulse(input int i);
        start[i] = 1'b1;
        step(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int k, dc;
        checks = 0; failures = 0; cyc = 0; mode = 0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; donecnt[i] = 0; st[i] = -1;
        end
        rst_n = 1'b0;
        step(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_stim", {ci_w[i], a_w[i], b_w[i]}, 0);
            chk("rst_flags", {busy_w[i], done_w[i], pass_w[i]}, 0);
            chk("rst_err", err_w[i], 0);
        end
        rst_n = 1'b1;
        step(2);

        // Good adder
        mode = 0;
        issue(1, 0, 1'b1, 1'b0, 3'd0);
        wait_idle(200);
        step(3);
        chk("pass_hold", pass_w[1], 1);

        // co stuck-at-0: 011,101,110,111 fail
        mode = 1;
        issue(1, 4, 1'b0, 1'b1, 3'b011);
        step(3);
        chk("pass_clr_on_start", pass_w[1], 0);
        wait_idle(200);

        // Inverted s: every vector fails
        mode = 2;
        issue(1, 8, 1'b0, 1'b1, 3'b000);
        wait_idle(200);
        step(2);
        chk("err_hold", err_w[1], 8);

        // Starts during a sweep are ignored; start right after done is accepted
        mode = 1;
        k = cyc;
        issue(1, 4, 1'b0, 1'b1, 3'b011);
        at(k + 5);  pulse(1);
        at(k + 20); pulse(1);
        at(k + 34);
        mode = 0;
        issue(1, 0, 1'b1, 1'b0, 3'd0);
        at(k + 37);
        chk("restart_busy", busy_w[1], 1);
        chk("restart_err_clr", err_w[1], 0);
        wait_idle(200);

        // Start in FIN is ignored
        k = cyc;
        issue(1, 0, 1'b1, 1'b0, 3'd0);
        at(k + 33);
        pulse(1);
        at(k + 35);
        chk("fin_start_busy", busy_w[1], 0);
        step(1);
        chk("fin_start_busy2", busy_w[1], 0);
        wait_idle(10);

        // Reset during SETTLE of vector 5
        mode = 2;
        k = cyc;
        issue(1, 8, 1'b0, 1'b1, 3'b000);
        at(k + 22);
        chk("pre_rst_stim", {ci_w[1], a_w[1], b_w[1]}, 5);
        chk("pre_rst_err", err_w[1], 5);
        dc = donecnt[1];
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_stim", {ci_w[1], a_w[1], b_w[1]}, 0);
        chk("midrst_flags", {busy_w[1], done_w[1], pass_w[1]}, 0);
        chk("midrst_err", err_w[1], 0);
`ifdef FA_BIST_FAIL_CAPTURE_EN
        chk("midrst_fail", {fvld_w[1], fvec_w[1]}, 0);
`endif
        sb.delete();
        step(1);
        rst_n = 1'b1;
        step(40);
        chk("no_done_after_rst", donecnt[1], dc);
        mode = 0;
        issue(1, 0, 1'b1, 1'b0, 3'd0);
        wait_idle(200);

        // Settle-time extremes
        issue(0, 0, 1'b1, 1'b0, 3'd0);
        wait_idle(200);
        issue(2, 0, 1'b1, 1'b0, 3'd0);
        wait_idle(400);
        mode = 2;
        issue(0, 8, 1'b0, 1'b1, 3'b000);
        wait_idle(200);

        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
